// File: rtl/qc_ldpc_encoder_controller.sv
// Control stage for the QC-LDPC encoder data path: buffers one row block of message bits,
// sequences the SRAA load/accumulate steps per block and hands out the final parity vector.
module qc_ldpc_encoder_controller #(
  parameter int unsigned Z          = 32,
  parameter int unsigned NUM_BLOCKS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         info_valid,
  output logic         info_ready,
  input  logic         info_in,
  input  logic [4:0]   counter_5bit_out,
  input  logic [1:0]   counter_2bit_out,
  input  logic [Z-1:0] generated_vector,
  output logic         clear_5bit_counter,
  output logic         clear_2bit_counter,
  output logic         increment_2bit_counter,
  output logic         load_SRAA_shift_reg,
  output logic         load_SRAA_reg,
  output logic         clear_SRAA,
  output logic         info_bit,
  output logic         parity_valid,
  input  logic         parity_ready,
  output logic [Z-1:0] parity_out,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(Z);
  localparam logic [CntW-1:0] LastSlot  = CntW'(Z - 1);
  localparam logic [4:0]      LastRow   = 5'(Z - 1);
  localparam logic [1:0]      LastBlock = 2'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {StInit, StFill, StLoad, StAcc, StOut} state_e;

  state_e          state_q;
  logic [Z-1:0]    buf_q;
  logic [CntW-1:0] fill_cnt_q;

  logic last_row;
  assign last_row = (counter_5bit_out == LastRow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      buf_q      <= '0;
      fill_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StInit: state_q <= StFill;
        StFill: begin
          // info_ready is constant 1 here, so info_valid alone is the handshake
          if (info_valid) begin
            buf_q[fill_cnt_q] <= info_in;
            if (fill_cnt_q == LastSlot) begin
              fill_cnt_q <= '0;
              state_q    <= StLoad;
            end else begin
              fill_cnt_q <= fill_cnt_q + CntW'(1);
            end
          end
        end
        StLoad: state_q <= StAcc;
        StAcc: begin
          if (last_row) begin
            state_q <= (counter_2bit_out == LastBlock) ? StOut : StFill;
          end
        end
        StOut: begin
          if (parity_ready) begin
            state_q <= StInit;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  always_comb begin
    info_ready             = 1'b0;
    clear_5bit_counter     = 1'b0;
    clear_2bit_counter     = 1'b0;
    increment_2bit_counter = 1'b0;
    load_SRAA_shift_reg    = 1'b0;
    load_SRAA_reg          = 1'b0;
    clear_SRAA             = 1'b0;
    info_bit               = 1'b0;
    parity_valid           = 1'b0;
    unique case (state_q)
      StInit: begin
        clear_SRAA         = 1'b1;
        clear_2bit_counter = 1'b1;
        clear_5bit_counter = 1'b1;
      end
      StFill: begin
        info_ready         = 1'b1;
        clear_5bit_counter = 1'b1;
      end
      StLoad: begin
        load_SRAA_shift_reg = 1'b1;
        clear_5bit_counter  = 1'b1;
      end
      StAcc: begin
        // The row counter was cleared in LOAD, so it doubles as the buffer slot index
        load_SRAA_reg          = 1'b1;
        info_bit               = buf_q[counter_5bit_out];
        increment_2bit_counter = last_row && (counter_2bit_out != LastBlock);
      end
      StOut: begin
        parity_valid       = 1'b1;
        clear_5bit_counter = 1'b1;
      end
      default: begin
        clear_SRAA         = 1'b1;
        clear_2bit_counter = 1'b1;
        clear_5bit_counter = 1'b1;
      end
    endcase
  end

  assign busy       = !((state_q == StFill) && (fill_cnt_q == '0));
  assign parity_out = generated_vector;

endmodule
